// File: rtl/tmds_lane_serializer.sv
// Parametrised soft serializer: NUM_CH data lanes plus a forwarded-clock lane,
// fed through a one-word valid/ready holding buffer, with idle fill and underrun flag.
module tmds_lane_serializer #(
  parameter int                 DATA_W    = 10,
  parameter int                 NUM_CH    = 3,
  parameter int                 LSB_FIRST = 1,
  parameter logic [DATA_W-1:0]  IDLE_WORD = 10'b1101010100,
  parameter logic [DATA_W-1:0]  CLK_WORD  = 10'b1111100000
) (
  input  logic                     SerialClk,
  input  logic                     RstB,
  input  logic                     Enable,
  input  logic [NUM_CH*DATA_W-1:0] InData,
  input  logic                     InValid,
  output logic                     InReady,
  output logic [NUM_CH-1:0]        SerOut,
  output logic                     ClkOut,
  output logic                     WordStart,
  output logic                     Running,
  output logic                     Underrun,
  input  logic                     UnderrunClr
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_buf_full;
  logic [NUM_CH*DATA_W-1:0]   r_buf;
  logic [DATA_W-1:0]          r_sh [NUM_CH];
  logic [DATA_W-1:0]          r_clk_sh;
  logic                       r_underrun;

  logic w_last;
  logic w_load;
  logic w_stop;
  logic w_accept;

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] v);
    if (LSB_FIRST != 0) shift_word = v >> 1;
    else                shift_word = v << 1;
  endfunction

  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    if (LSB_FIRST != 0) out_bit = v[0];
    else                out_bit = v[DATA_W-1];
  endfunction

  assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_BIT);
  assign w_load   = Enable && ((r_state == S_IDLE) || w_last);
  assign w_stop   = w_last && !Enable;
  // Reset gates InReady so nothing is accepted while the block is held in reset.
  assign InReady  = RstB && (!r_buf_full || (w_last && Enable));
  assign w_accept = InValid && InReady;

  always_ff @(posedge SerialClk or negedge RstB) begin
    if (!RstB) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_buf_full <= 1'b0;
      r_clk_sh   <= '0;
      r_underrun <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) r_sh[c] <= '0;
    end else begin
      if (w_load) begin
        r_state  <= S_RUN;
        r_cnt    <= '0;
        r_clk_sh <= CLK_WORD;
        for (int c = 0; c < NUM_CH; c++)
          r_sh[c] <= r_buf_full ? r_buf[c*DATA_W +: DATA_W] : IDLE_WORD;
      end else if (w_stop) begin
        // Clearing the shift registers keeps the lanes at 0 for the whole idle period.
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_clk_sh <= '0;
        for (int c = 0; c < NUM_CH; c++) r_sh[c] <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt    <= r_cnt + CNT_W'(1);
        r_clk_sh <= shift_word(r_clk_sh);
        for (int c = 0; c < NUM_CH; c++) r_sh[c] <= shift_word(r_sh[c]);
      end

      // A same-edge accept refills the buffer that the load is draining.
      if (w_accept)    r_buf_full <= 1'b1;
      else if (w_load) r_buf_full <= 1'b0;

      if (w_load && !r_buf_full) r_underrun <= 1'b1;
      else if (UnderrunClr)      r_underrun <= 1'b0;
    end
  end

  always_ff @(posedge SerialClk) begin
    if (w_accept) r_buf <= InData;
  end

  always_comb begin
    SerOut = '0;
    for (int c = 0; c < NUM_CH; c++) SerOut[c] = out_bit(r_sh[c]);
  end

  assign ClkOut    = out_bit(r_clk_sh);
  assign Running   = (r_state == S_RUN);
  assign WordStart = Running && (r_cnt == '0);
  assign Underrun  = r_underrun;

endmodule

// File: tb/tb_tmds_lane_serializer.sv
// Randomised bench for tmds_lane_serializer against a word/bit-index reference model,
// plus a directed MSB-first 8-bit instance.
module tb_tmds_lane_serializer;

  localparam int W   = 10;
  localparam int NCH = 3;
  localparam logic [W-1:0] IDLE_W = 10'b1101010100;
  localparam logic [W-1:0] CLK_W  = 10'b1111100000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             en, valid, clr;
  logic [NCH*W-1:0] data;
  logic             ready, clko, ws, run, und;
  logic [NCH-1:0]   ser;

  logic       d8_en, d8_valid;
  logic [7:0] d8_data;
  logic       d8_ready, d8_clk, d8_ws, d8_run, d8_und;
  logic [0:0] d8_ser;

  tmds_lane_serializer #(.DATA_W(W), .NUM_CH(NCH), .LSB_FIRST(1),
                         .IDLE_WORD(IDLE_W), .CLK_WORD(CLK_W)) dut (
    .SerialClk(clk), .RstB(rst_n), .Enable(en), .InData(data), .InValid(valid),
    .InReady(ready), .SerOut(ser), .ClkOut(clko), .WordStart(ws), .Running(run),
    .Underrun(und), .UnderrunClr(clr));

  tmds_lane_serializer #(.DATA_W(8), .NUM_CH(1), .LSB_FIRST(0),
                         .IDLE_WORD(8'h3C), .CLK_WORD(8'hF0)) dut8 (
    .SerialClk(clk), .RstB(rst_n), .Enable(d8_en), .InData(d8_data), .InValid(d8_valid),
    .InReady(d8_ready), .SerOut(d8_ser), .ClkOut(d8_clk), .WordStart(d8_ws), .Running(d8_run),
    .Underrun(d8_und), .UnderrunClr(1'b0));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: current word per lane, index of the bit on the wire, one-word buffer.
  logic [W-1:0] m_cur [NCH];
  logic [W-1:0] m_buf [NCH];
  logic [W-1:0] m_clkw;
  int           m_pos;
  bit           m_run, m_full, m_under, m_rdy;

  task automatic model_reset();
    m_run = 0; m_full = 0; m_under = 0; m_pos = 0;
    for (int c = 0; c < NCH; c++) begin m_cur[c] = '0; m_buf[c] = '0; end
  endtask

  task automatic model_edge();
    bit ld, acc, setu;
    bit at_end;
    at_end = m_run && (m_pos == W-1);
    acc  = valid && (!m_full || (at_end && en));
    ld   = en && (!m_run || at_end);
    setu = 0;
    if (ld) begin
      for (int c = 0; c < NCH; c++) m_cur[c] = m_full ? m_buf[c] : IDLE_W;
      setu   = !m_full;
      m_full = 0;
      m_pos  = 0;
      m_run  = 1;
    end else if (at_end) begin
      m_run = 0;
      m_pos = 0;
    end else if (m_run) begin
      m_pos++;
    end
    if (setu)     m_under = 1;
    else if (clr) m_under = 0;
    if (acc) begin
      for (int c = 0; c < NCH; c++) m_buf[c] = data[c*W +: W];
      m_full = 1;
    end
  endtask

  task automatic check_outputs();
    logic [NCH-1:0] exp_ser;
    for (int c = 0; c < NCH; c++) exp_ser[c] = m_run ? m_cur[c][m_pos] : 1'b0;
    check_val("SerOut",    32'(ser),  32'(exp_ser));
    check_val("ClkOut",    32'(clko), 32'(m_run ? m_clkw[m_pos] : 1'b0));
    check_val("WordStart", 32'(ws),   32'(m_run && m_pos == 0));
    check_val("Running",   32'(run),  32'(m_run));
    check_val("Underrun",  32'(und),  32'(m_under));
  endtask

  task automatic cycle(input bit e, input bit v, input logic [NCH*W-1:0] d, input bit cl);
    @(negedge clk);
    check_outputs();
    en = e; valid = v; data = d; clr = cl;
    #1;
    m_rdy = !m_full || (m_run && m_pos == W-1 && e);
    check_val("InReady", 32'(ready), 32'(m_rdy));
    model_edge();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_val("rst_SerOut",  32'(ser),  0);
    check_val("rst_ClkOut",  32'(clko), 0);
    check_val("rst_WS_Run",  32'({ws, run}), 0);
    check_val("rst_Under",   32'(und),  0);
    check_val("rst_InReady", 32'(ready), 0);
    model_reset();
    en = 0; valid = 0; clr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rel_InReady", 32'(ready), 1);
  endtask

  initial begin
    logic [NCH*W-1:0] words [3];
    logic [NCH*W-1:0] rd;
    logic [7:0]       e8;
    bit               pend, v, e;
    int               guard;

    m_clkw = CLK_W;
    model_reset();
    rst_n = 1'b0; en = 0; valid = 0; clr = 0; data = '0;
    d8_en = 0; d8_valid = 0; d8_data = '0;
    #12;
    check_val("init_InReady", 32'(ready), 0);
    check_val("init_SerOut",  32'(ser), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("init_rel_InReady", 32'(ready), 1);

    // MSB-first 8-bit lane: 0xA5 must appear as 1,0,1,0,0,1,0,1
    @(negedge clk);
    d8_valid = 1; d8_data = 8'hA5;
    @(negedge clk);
    d8_valid = 0; d8_en = 1;
    e8 = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("d8_SerOut", 32'(d8_ser[0]), 32'(e8[7-i]));
      if (i == 0) check_val("d8_WordStart", 32'(d8_ws), 1);
    end
    d8_en = 0;

    // Enable with empty buffer: idle words and underrun
    for (int i = 0; i < 25; i++) cycle(1, 0, '0, 0);

    // Back-to-back words after clearing underrun
    words[0] = {10'h3FF, 10'h155, 10'h2DB};
    words[1] = {10'h2DB, 10'h3FF, 10'h155};
    words[2] = {10'h155, 10'h2DB, 10'h3FF};
    cycle(1, 0, '0, 1);
    guard = 0;
    for (int i = 0; i < 45; i++) begin
      cycle(1, 1, words[guard], 0);
      if (m_rdy) guard = (guard + 1) % 3;
    end

    // Drop Enable while bit 3 is on the wire, keep a word buffered, then resume
    guard = 0;
    while (!(m_run && m_pos == 3) && guard < 40) begin
      cycle(1, 1, words[0], 0);
      guard++;
    end
    check_val("drop_reached", 32'(guard < 40), 1);
    for (int i = 0; i < 15; i++) cycle(0, 1, words[1], 0);
    for (int i = 0; i < 25; i++) cycle(1, 0, '0, 0);

    // Clear held high while underruns keep occurring: set wins at load edges
    for (int i = 0; i < 25; i++) cycle(1, 0, '0, 1);
    cycle(0, 0, '0, 1);
    for (int i = 0; i < 12; i++) cycle(0, 0, '0, 1);

    // Random traffic, holding data stable while stalled
    pend = 0; rd = '0;
    for (int i = 0; i < 400; i++) begin
      e = ($urandom_range(0, 19) != 0);
      if (!pend) begin
        v  = ($urandom_range(0, 3) != 0);
        rd = (NCH*W)'({$urandom(), $urandom()});
      end else begin
        v = 1;
      end
      cycle(e, v, rd, ($urandom_range(0, 9) == 0));
      pend = v && !m_rdy;
    end

    // Asynchronous reset mid-word, then more random traffic
    guard = 0;
    while (!(m_run && m_pos == 4) && guard < 40) begin
      cycle(1, 1, words[2], 0);
      guard++;
    end
    pulse_reset();
    pend = 0;
    for (int i = 0; i < 150; i++) begin
      e = ($urandom_range(0, 9) != 0);
      if (!pend) begin
        v  = ($urandom_range(0, 1) != 0);
        rd = (NCH*W)'({$urandom(), $urandom()});
      end else begin
        v = 1;
      end
      cycle(e, v, rd, ($urandom_range(0, 7) == 0));
      pend = v && !m_rdy;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/tmds_lane_serializer.md
Name: tmds_lane_serializer

Overview:
Parametrised, single-clock soft serializer for TMDS-style links. It converts NUM_CH parallel DATA_W-bit words into NUM_CH serial lanes, plus one forwarded-clock lane, all running in the SerialClk domain. Upstream logic feeds it through a valid/ready handshake backed by a one-word holding buffer. It replaces the fixed 10:1 per-lane serializer wherever a parametrised ratio, lane count, bit order, idle fill or underrun detection is needed.

Parameters:
DATA_W, 10, bits per word (serialization ratio); legal range 2..16.
NUM_CH, 3, number of data lanes.
LSB_FIRST, 1, 1 = bit 0 transmitted first; 0 = bit DATA_W-1 first.
IDLE_WORD, 10'b1101010100, word loaded on every lane when the buffer is empty at a word boundary.
CLK_WORD, 10'b1111100000, pattern emitted on the clock lane for every word.

Ports:
SerialClk  in  1  bit clock; every register is clocked on its rising edge.
RstB  in  1  asynchronous, active-low reset.
Enable  in  1  run request.
InData  in  NUM_CH*DATA_W  lane c occupies bits [c*DATA_W +: DATA_W].
InValid  in  1  InData is valid.
InReady  out  1  buffer can accept; a transfer occurs when InValid & InReady at a rising edge.
SerOut  out  NUM_CH  serial data, one bit per lane.
ClkOut  out  1  forwarded-clock lane.
WordStart  out  1  high during the cycle in which bit 0 of a word is on SerOut.
Running  out  1  high in the RUN state.
Underrun  out  1  sticky flag: IDLE_WORD was substituted at least once.
UnderrunClr  in  1  clears Underrun.

Behaviour:
- Reset (RstB low, asynchronous):
  - state = IDLE, BitCnt = 0, buffer empty, all shift registers 0.
  - SerOut = 0, ClkOut = 0, WordStart = 0, Running = 0, Underrun = 0.
  - InReady = 0 while RstB is low; InReady = 1 from the first cycle after release.
- State IDLE:
  - SerOut, ClkOut, WordStart and Running are all 0.
  - The buffer can still be filled; InReady = ~BufFull.
  - Leaving IDLE: if Enable = 1 at an edge, that edge is a load edge and the state becomes RUN.
- State RUN:
  - BitCnt counts 0..DATA_W-1 and wraps to 0.
  - A load edge is the edge at which BitCnt = DATA_W-1. The entry edge from IDLE is also a load edge.
  - At a load edge:
    - If BufFull: each lane shift register takes the buffered word and the buffer is emptied.
    - If the buffer is empty: every lane takes IDLE_WORD and Underrun is set.
    - The clock shift register takes CLK_WORD.
    - BitCnt becomes 0.
  - Other edges: shift registers shift by one toward the output end, as selected by LSB_FIRST.
  - SerOut[c] and ClkOut are driven directly from the output-end flop. The first bit therefore appears in the cycle immediately after the load edge. There is no combinational path from InData to SerOut.
  - WordStart = Running & (BitCnt == 0).
- Enable deasserted in RUN:
  - The current word always completes.
  - At the next load edge, if Enable = 0, the block performs no load, returns to IDLE and drives outputs to 0.
  - The buffer contents are retained.
- Handshake:
  - InReady = ~BufFull | LoadEdgeNow, where LoadEdgeNow = RUN & (BitCnt == DATA_W-1) & Enable.
  - Simultaneous load and accept: the shift registers take the old buffer word and the buffer takes the new word.
  - No bypass: if the buffer is empty at a load edge, an InData accepted at that same edge goes into the buffer and IDLE_WORD is transmitted.
  - InData must be held stable while InValid = 1 and InReady = 0.
- Throughput: one word per DATA_W cycles. Word latency from acceptance to first bit is at most 2*DATA_W cycles.
- Underrun:
  - Cleared by UnderrunClr = 1 at an edge.
  - If a set and a clear occur at the same edge, the set wins.
- BitCnt width is clog2(DATA_W); it never exceeds DATA_W-1.
- Reset asserted mid-word: the block aborts immediately to the reset values; no partial word resumes.

Test Plan:
1. Reset, then Enable = 1 with the buffer empty → SerOut carries IDLE_WORD LSB-first (0,0,1,0,1,0,1,0,1,1) on every lane; ClkOut carries 0,0,0,0,0,1,1,1,1,1; WordStart pulses every 10 cycles; Underrun = 1.
2. Back-to-back InValid with words 0x2DB, 0x155, 0x3FF on lanes 0/1/2 → continuous serial output with no IDLE_WORD insertion; InReady is high once per 10 cycles while the buffer is full; Underrun stays 0 after a clear.
3. LSB_FIRST = 0, DATA_W = 8, word 0xA5 → SerOut = 1,0,1,0,0,1,0,1.
4. Enable dropped at BitCnt = 3 → the remaining 6 bits are sent, then Running = 0 and SerOut = 0; a buffered word is sent first after Enable is re-raised.
5. UnderrunClr and an underrun load on the same edge → Underrun = 1; a clear alone → 0.
6. RstB pulsed low mid-word → all outputs are 0 asynchronously; after release the buffer is empty and InReady = 1.
